// File: rtl/led_pkg.sv
// led_pkg: control-register layout, reset value and off-word helpers for the LED PWM driver.
package led_pkg;
  localparam int DUTY_LSB = 0;
  function automatic int blink_en_bit(int pwm_bits);
    return pwm_bits;
  endfunction
  function automatic int enable_bit(int pwm_bits);
    return pwm_bits + 1;
  endfunction
  function automatic logic [31:0] ctrl_mask(int pwm_bits);
    return (32'h1 << (pwm_bits + 2)) - 32'h1;
  endfunction
  function automatic logic [31:0] ctrl_reset(int pwm_bits);
    return (32'h1 << enable_bit(pwm_bits)) | ((32'h1 << pwm_bits) - 32'h1);
  endfunction
  function automatic logic [31:0] off_word(bit active_low);
    return active_low ? 32'hffff_ffff : 32'h0000_0000;
  endfunction
endpackage

// File: rtl/led_frame_timer.sv
// led_frame_timer: PWM frame counter, blink frame counter and blink phase.
module led_frame_timer
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] cnt_o,
  output logic                frame_sync_o,
  output logic                blink_phase_o
);
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [BLINK_LOG2-1:0] fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  always_comb begin
    frame_sync_o  = &cnt_q;
    cnt_d         = cnt_q + 1'b1;
    fcnt_d        = frame_sync_o ? fcnt_q + 1'b1 : fcnt_q;
    phase_d       = phase_q ^ (frame_sync_o & (&fcnt_q));
    cnt_o         = cnt_q;
    blink_phase_o = phase_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: drives LED pins from a pattern word with global PWM brightness and blink.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS       = 8,
  parameter int BLINK_LOG2     = 6,
  parameter bit LED_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] pattern_in,
  output logic [31:0] led_out,
  output logic        frame_sync
);
  localparam int          BL   = blink_en_bit(PWM_BITS);
  localparam int          EN   = enable_bit(PWM_BITS);
  localparam logic [31:0] MASK = ctrl_mask(PWM_BITS);
  localparam logic [31:0] CRST = ctrl_reset(PWM_BITS);
  localparam logic [31:0] OFF  = off_word(LED_ACTIVE_LOW);
  logic [31:0]         ctrl_q, ctrl_d, pat_q, pat_d, led_q, led_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, cnt;
  logic                blink_phase, gate;
  led_frame_timer #(.PWM_BITS(PWM_BITS), .BLINK_LOG2(BLINK_LOG2)) u_timer (
    .clk(clk), .rst(rst), .cnt_o(cnt), .frame_sync_o(frame_sync), .blink_phase_o(blink_phase)
  );
  // a write landing on the boundary cycle feeds the next frame's duty directly
  always_comb begin
    ctrl_d  = we ? din & MASK : ctrl_q;
    pat_d   = frame_sync ? pattern_in : pat_q;
    duty_d  = frame_sync ? (we ? din[DUTY_LSB +: PWM_BITS] : ctrl_q[DUTY_LSB +: PWM_BITS]) : duty_q;
    gate    = ((&duty_q) | (cnt < duty_q)) & ctrl_q[EN] & ~(ctrl_q[BL] & blink_phase);
    led_d   = gate ? pat_q : OFF;
    dout    = ctrl_q;
    led_out = led_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= CRST;
      pat_q  <= OFF;
      duty_q <= '1;
      led_q  <= OFF;
    end else begin
      ctrl_q <= ctrl_d;
      pat_q  <= pat_d;
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized check of led_pwm_driver against a cycle-count based reference model.
module tb_led_pwm_driver;
  logic        clk = 1'b0, rst = 1'b0, we = 1'b0, frame_sync;
  logic [31:0] din = '0, dout, pattern_in = 32'h0000_00f0, led_out;
  int          checks = 0, errors = 0;
  int          m_t;
  logic [31:0] m_ctrl, m_pat, m_led;
  int          m_duty;
  led_pwm_driver #(.PWM_BITS(4), .BLINK_LOG2(1), .LED_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .we(we), .din(din), .dout(dout),
    .pattern_in(pattern_in), .led_out(led_out), .frame_sync(frame_sync)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at t=%0t", tag, got, exp, $time);
    end
  endtask
  // model: cycle index since reset gives cnt = t mod 16, completed frames = t / 16,
  // blink phase flips every 2 frames
  task automatic step();
    int          c, ph;
    bit          gate;
    logic [31:0] nled;
    c    = m_t % 16;
    ph   = ((m_t / 16) / 2) % 2;
    gate = ((m_duty == 15) || (c < m_duty)) && m_ctrl[5] && !(m_ctrl[4] && ph == 1);
    nled = gate ? m_pat : 32'hffff_ffff;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_t = 0; m_ctrl = 32'h2f; m_pat = 32'hffff_ffff; m_duty = 15; m_led = 32'hffff_ffff;
    end else begin
      m_led = nled;
      if (c == 15) begin
        m_pat  = pattern_in;
        m_duty = we ? int'(din[3:0]) : int'(m_ctrl[3:0]);
      end
      if (we) m_ctrl = din & 32'h3f;
      m_t++;
    end
    check("led_out", led_out, m_led);
    check("dout", dout, m_ctrl);
    check("frame_sync", {31'b0, frame_sync}, {31'b0, (m_t % 16) == 15});
  endtask
  initial begin
    m_t = 0; m_ctrl = 32'h2f; m_pat = 32'hffff_ffff; m_duty = 15; m_led = 32'hffff_ffff;
    repeat (3) step();
    rst = 1'b1;
    repeat (40) step();
    check("steady_on", led_out, 32'h0000_00f0);
    for (int i = 0; i < 4000; i++) begin
      we  = ($urandom % 25) == 0;
      din = $urandom;
      if (($urandom % 4) != 0) din[5] = 1'b1;
      if (($urandom % 3) == 0) din[3:0] = 4'hf;
      if (($urandom % 15) == 0) pattern_in = $urandom;
      rst = ($urandom % 500) != 0;
      step();
    end
    we = 1'b0; rst = 1'b1;
    repeat (20) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Sits between the 32-bit LED output register and the board LED pins.
- Consumes the register's 32-bit pattern word and drives the pins with a global PWM brightness and an optional blink.
- Has its own bus-writable control register.
- Takes pattern and duty updates only at PWM frame boundaries, so the pins never glitch mid-frame.

Parameters:
- PWM_BITS, 8: width of the PWM frame counter; one frame = 2^PWM_BITS cycles.
- BLINK_LOG2, 6: blink phase toggles every 2^BLINK_LOG2 frames.
- LED_ACTIVE_LOW, 1: 1 = pin level 1 is LED off (off word 32'hffffffff); 0 = off word 32'h00000000.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- we  in  1  control register write strobe from bus bridge
- din  in  32  control write data
- dout  out  32  control register readback
- pattern_in  in  32  LED pattern from the LED output register; raw pin levels
- led_out  out  32  board LED pins
- frame_sync  out  1  one-cycle pulse on the last cycle of each PWM frame

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-low.
- Control register ctrl:
  - [PWM_BITS-1:0] duty
  - [PWM_BITS] blink_en
  - [PWM_BITS+1] enable
  - All other bits read 0.
  - Reset value: duty all ones, blink_en 0, enable 1.
  - we=1 writes ctrl from din at the clock edge; dout = ctrl, combinational from the register.
- Frame counter cnt (PWM_BITS wide):
  - Reset 0; increments every cycle; wraps from all-ones to 0.
  - frame_sync = (cnt == all-ones); reset value 0.
- Boundary latch, at the edge where cnt == all-ones:
  - shadow_pat <= pattern_in.
  - shadow_duty <= (we ? din duty field : ctrl duty); a simultaneous write takes effect in the next frame.
  - Reset: shadow_pat = off word, shadow_duty = all ones.
  - pattern_in changes mid-frame have no effect until the next boundary.
- Blink:
  - frame counter fcnt (BLINK_LOG2 bits) increments at each boundary.
  - blink_phase toggles at the boundary where fcnt wraps to 0.
  - Both reset to 0.
  - Clearing blink_en does not reset fcnt or blink_phase.
- Gate:
  - on = (shadow_duty == all-ones) | (cnt < shadow_duty).
  - duty 0 means always off; duty all-ones means always on.
  - gate = on & ctrl.enable & ~(ctrl.blink_en & blink_phase).
- Output:
  - Registered: led_out <= gate ? shadow_pat : off word.
  - One cycle of latency from cnt/gate to pin.
  - Reset value: off word (32'hffffffff with the default parameter).
- enable = 0: led_out is the off word from the next edge; counters keep running.
- Reset mid-frame: all state returns to reset values at that edge; the frame restarts from cnt=0.

Decomposition:
- Shared package led_pkg holds:
  - ctrl field positions and widths (DUTY_LSB, BLINK_EN_BIT, ENABLE_BIT, as functions of PWM_BITS);
  - the CTRL_RESET value;
  - the OFF_WORD constant derived from LED_ACTIVE_LOW.
- One sub-module, led_frame_timer, owns cnt, fcnt, blink_phase and frame_sync, with outputs cnt, frame_sync and blink_phase.
- The top level keeps ctrl, the shadow registers, the gate logic and the output register.

Test Plan (PWM_BITS=4, BLINK_LOG2=1):
- Reset, then release with pattern_in=32'h0000_00F0 held:
  - led_out = 32'hffffffff and dout = 32'h0000_002F during reset and cycles 0-15;
  - from cycle 17, led_out = 32'h0000_00F0 continuously (duty 0xF is always on).
- Write din=32'h0000_0024 (duty 4, enable) at cycle 5, with pattern_in=32'h0:
  - frame 1 unchanged (always on);
  - from frame 2, led_out = 32'h0 for 4 cycles, then 32'hffffffff for 12 cycles, per frame.
  - Frame and cycle numbering assume a pin that is always on in frame 1 and follows the duty from frame 2.
- Change pattern_in from 32'h0 to 32'h5 at mid-frame cnt=7 with duty 0xF:
  - led_out stays 32'h0 until the pin cycle after the cnt==15 edge, then 32'h5.
- Write ctrl=32'h0000_003F (blink on) with pattern_in=32'h0:
  - after the next two boundaries, blink_phase=1;
  - led_out = 32'hffffffff for 2 frames, then 32'h0 for 2 frames, repeating.
- Write at the exact cnt==15 cycle with din=32'h0000_0020 (duty 0):
  - the next frame's led_out is entirely 32'hffffffff;
  - frame_sync pulses once every 16 cycles throughout.
- Assert rst=0 at cnt=9 while blink is on:
  - the next edge gives led_out=32'hffffffff, dout=32'h2F and frame_sync=0;
  - after release, frame_sync first pulses 16 cycles later.
